fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch sequencer sitting between the program counter,
// a registered-read instruction memory (MAR) and the decoder.
//
// Each fetch walks ADDR -> WAIT -> CAPTURE -> HOLD. The memory needs two cycles
// after an address change: one for its read register and one to settle. The
// captured instruction is then offered to the decoder through a valid/ready
// handshake. On that handshake the PC advances (or jumps) and the next fetch
// starts. Consuming HALT_OPCODE parks the unit in HALT until reset.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   HALT_OPCODE  opcode that stops fetching once consumed
//
// Ports
//   clk              rising-edge clock, shared with the MAR
//   rst_n            asynchronous active-low reset
//   start            pulse: begin fetching from the current PC (IDLE only)
//   mar_address[7:0] address to the MAR (always equals the PC)
//   mar_instruction  MAR read data, valid 2 cycles after mar_address changes
//   ir_out[7:0]      captured instruction for the decoder
//   ir_valid         ir_out holds an unconsumed instruction
//   ir_ready         decoder accepts ir_out when high together with ir_valid
//   jump_en          on the handshake cycle, load jump_addr as the next PC
//   jump_addr[7:0]   jump target
//   pc_out[7:0]      current program counter
//   halted           high in HALT
//   fetch_count[15:0] (only with FETCH_UNIT_FETCH_COUNT_EN) saturating count
//                    of completed handshakes
//
// Build option
//   FETCH_UNIT_FETCH_COUNT_EN  when defined, adds the fetch_count port and its
//                              counter; when undefined, neither exists.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  mar_address,
  input  logic [7:0]  mar_instruction,
  output logic [7:0]  ir_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        jump_en,
  input  logic [7:0]  jump_addr,
  output logic [7:0]  pc_out,
  output logic        halted
`ifdef FETCH_UNIT_FETCH_COUNT_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    CAPTURE,
    HOLD,
    HALT
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic       handshake;

  // ir_valid is only ever high in HOLD, so this is the sole acceptance point.
  // While ir_valid is low, ir_ready has no effect.
  assign handshake = ir_valid & ir_ready;

  // The MAR address is the PC register itself. It therefore moves only when
  // the PC does, and it is glitch-free.
  assign mar_address = pc;
  assign pc_out      = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir_out   <= 8'h00;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ADDR;
          end
        end

        // The address has been stable since entering ADDR. The MAR registers
        // it on this edge and the data settles during WAIT.
        ADDR: begin
          state <= WAIT;
        end

        WAIT: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          ir_out   <= mar_instruction;
          ir_valid <= 1'b1;
          state    <= HOLD;
        end

        HOLD: begin
          if (handshake) begin
            ir_valid <= 1'b0;
            if (ir_out == HALT_OPCODE) begin
              // The PC is left pointing at the halt instruction.
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              // The 8-bit add wraps FF -> 00 on its own.
              pc    <= jump_en ? jump_addr : (pc + 8'd1);
              state <= ADDR;
            end
          end
        end

        HALT: begin
          halted   <= 1'b1;
          ir_valid <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_UNIT_FETCH_COUNT_EN
  // Counts accepted instructions, including the one that halts the unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 16'h0000;
    end else if (handshake && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 00)
  logic       rst_n, start, ir_ready, jump_en;
  logic [7:0] jump_addr, mar_address, mar_instruction, ir_out, pc_out;
  logic       ir_valid, halted;
`ifdef FETCH_UNIT_FETCH_COUNT_EN
  logic [15:0] fetch_count, fetch_count2;
`endif

  // Second DUT (RESET_PC = FF) for the PC-wrap scenario
  logic       rst_n2, start2, ir_ready2;
  logic [7:0] mar_address2, mar_instruction2, ir_out2, pc_out2;
  logic       ir_valid2, halted2;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mar_address(mar_address),
    .mar_instruction(mar_instruction), .ir_out(ir_out), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .jump_en(jump_en), .jump_addr(jump_addr),
    .pc_out(pc_out), .halted(halted)
`ifdef FETCH_UNIT_FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  fetch_unit #(.RESET_PC(8'hFF), .HALT_OPCODE(8'hFF)) u_wrap (
    .clk(clk), .rst_n(rst_n2), .start(start2), .mar_address(mar_address2),
    .mar_instruction(mar_instruction2), .ir_out(ir_out2), .ir_valid(ir_valid2),
    .ir_ready(ir_ready2), .jump_en(1'b0), .jump_addr(8'h00),
    .pc_out(pc_out2), .halted(halted2)
`ifdef FETCH_UNIT_FETCH_COUNT_EN
    , .fetch_count(fetch_count2)
`endif
  );

  // Instruction memory with a registered read port; the second cycle of
  // latency is the settle time the fetch unit waits out in WAIT.
  logic [7:0] mem [0:255];
  logic [7:0] mar_q, mar_q2;
  always @(posedge clk) begin
    mar_q  <= mem[mar_address];
    mar_q2 <= mem[mar_address2];
  end
  assign mar_instruction  = mar_q;
  assign mar_instruction2 = mar_q2;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level reference model of the main DUT: a fetch begun now
  // delivers mem[pc] three edges later; an accepted instruction either halts
  // or moves the PC and begins the next fetch.
  bit         m_idle, m_halted, m_valid;
  int         m_timer;
  logic [7:0] m_pc, m_ir;
  int         m_count;

  task automatic model_reset();
    m_idle = 1; m_halted = 0; m_valid = 0; m_timer = 0;
    m_pc = 8'h00; m_ir = 8'h00; m_count = 0;
  endtask

  task automatic model_step(input logic st, input logic rdy, input logic jen,
                            input logic [7:0] ja);
    if (m_halted) begin
      // only reset leaves HALT
    end else if (m_idle) begin
      if (st) begin m_idle = 0; m_timer = 3; end
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 0;
        if (m_count < 65535) m_count++;
        if (m_ir == 8'hFF) m_halted = 1;
        else begin
          m_pc    = jen ? ja : 8'((int'(m_pc) + 1) % 256);
          m_timer = 3;
        end
      end
    end else if (m_timer > 0) begin
      m_timer--;
      if (m_timer == 0) begin m_valid = 1; m_ir = mem[m_pc]; end
    end
  endtask

  // One clock of the main DUT: inputs driven #1 after an edge, outputs
  // observed #1 after the next edge.
  task automatic cyc(input logic st, input logic rdy, input logic jen,
                     input logic [7:0] ja);
    start = st; ir_ready = rdy; jump_en = jen; jump_addr = ja;
    @(posedge clk);
    model_step(st, rdy, jen, ja);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; start = 0; ir_ready = 0; jump_en = 0; jump_addr = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (pc_out !== 8'h00) $display("FAIL reset_pc: got %h want 00", pc_out); else n_pass++;
    n_checks++; if (mar_address !== 8'h00) $display("FAIL reset_mar: got %h want 00", mar_address); else n_pass++;
    n_checks++; if (ir_out !== 8'h00) $display("FAIL reset_ir: got %h want 00", ir_out); else n_pass++;
    n_checks++; if (ir_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ir_valid); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    n_checks++; if (pc_out2 !== 8'hFF) $display("FAIL reset_pc_param: got %h want ff", pc_out2); else n_pass++;
    n_checks++; if (mar_address2 !== 8'hFF) $display("FAIL reset_mar_param: got %h want ff", mar_address2); else n_pass++;
`ifdef FETCH_UNIT_FETCH_COUNT_EN
    n_checks++; if (fetch_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", fetch_count); else n_pass++;
`endif
    rst_n = 1;
    model_reset();
    $display("test_reset: done");
  endtask

  // Program 01, 04, 10, FF: three in-order fetches then a halt.
  task automatic test_sequence();
    logic [7:0] exp_ir [0:2];
    int lat;
    exp_ir[0] = 8'h01; exp_ir[1] = 8'h04; exp_ir[2] = 8'h10;
    mem[0] = 8'h01; mem[1] = 8'h04; mem[2] = 8'h10; mem[3] = 8'hFF;
    do_reset();
    cyc(1, 1, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      while (!ir_valid && lat < 10) begin cyc(0, 1, 0, 8'h00); lat++; end
      n_checks++; if (lat != 3) $display("FAIL seq_latency[%0d]: got %0d want 3", k, lat); else n_pass++;
      n_checks++; if (ir_out !== exp_ir[k]) $display("FAIL seq_ir[%0d]: got %h want %h", k, ir_out, exp_ir[k]); else n_pass++;
      n_checks++; if (pc_out !== 8'(k)) $display("FAIL seq_pc[%0d]: got %h want %h", k, pc_out, 8'(k)); else n_pass++;
      $display("seq fetch %0d: ir=%h pc=%h latency=%0d", k, ir_out, pc_out, lat);
      cyc(0, 1, 0, 8'h00);
      n_checks++; if (ir_valid !== 1'b0) $display("FAIL seq_valid_clear[%0d]: got %b want 0", k, ir_valid); else n_pass++;
      n_checks++; if (pc_out !== 8'(k + 1)) $display("FAIL seq_pc_next[%0d]: got %h want %h", k, pc_out, 8'(k + 1)); else n_pass++;
    end
  endtask

  // Continues from test_sequence: memory[03] = FF is fetched and accepted.
  task automatic test_halt();
    int lat = 0;
    while (!ir_valid && lat < 10) begin cyc(0, 1, 0, 8'h00); lat++; end
    n_checks++; if (ir_out !== 8'hFF) $display("FAIL halt_ir: got %h want ff", ir_out); else n_pass++;
    cyc(0, 1, 0, 8'h00);
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_flag: got %b want 1", halted); else n_pass++;
    n_checks++; if (ir_valid !== 1'b0) $display("FAIL halt_valid: got %b want 0", ir_valid); else n_pass++;
    n_checks++; if (pc_out !== 8'h03) $display("FAIL halt_pc: got %h want 03", pc_out); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1, 8'h55);
      n_checks++; if (halted !== 1'b1 || ir_valid !== 1'b0 || pc_out !== 8'h03)
        $display("FAIL halt_sticky[%0d]: got halted=%b valid=%b pc=%h want 1 0 03", i, halted, ir_valid, pc_out);
      else n_pass++;
    end
    $display("halt: halted=%b pc=%h", halted, pc_out);
    do_reset();
    n_checks++; if (halted !== 1'b0) $display("FAIL halt_reset: got %b want 0", halted); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 8'h00);
      n_checks++; if (ir_valid !== 1'b0 || pc_out !== 8'h00)
        $display("FAIL halt_idle[%0d]: got valid=%b pc=%h want 0 00", i, ir_valid, pc_out);
      else n_pass++;
    end
  endtask

  // Decoder stalls 5 cycles in HOLD; a jump pulse during the stall is ignored.
  task automatic test_stall();
    mem[0] = 8'h21;
    do_reset();
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 8'h80);
      n_checks++; if (ir_valid !== 1'b1 || ir_out !== 8'h21 || pc_out !== 8'h00)
        $display("FAIL stall_hold[%0d]: got valid=%b ir=%h pc=%h want 1 21 00", i, ir_valid, ir_out, pc_out);
      else n_pass++;
    end
    cyc(0, 1, 0, 8'h00);
    n_checks++; if (pc_out !== 8'h01) $display("FAIL stall_release_pc: got %h want 01", pc_out); else n_pass++;
    n_checks++; if (ir_valid !== 1'b0) $display("FAIL stall_release_valid: got %b want 0", ir_valid); else n_pass++;
    $display("stall: released pc=%h", pc_out);
  endtask

  // Continues in ADDR at pc=01: jump pulses during the fetch do nothing; a
  // jump on the handshake redirects the next address to 80.
  task automatic test_jump();
    mem[1] = 8'h33; mem[8'h80] = 8'h44;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h80);
    n_checks++; if (ir_valid !== 1'b1 || ir_out !== 8'h33 || pc_out !== 8'h01)
      $display("FAIL jump_ignored: got valid=%b ir=%h pc=%h want 1 33 01", ir_valid, ir_out, pc_out);
    else n_pass++;
    cyc(0, 1, 1, 8'h80);
    n_checks++; if (mar_address !== 8'h80) $display("FAIL jump_mar: got %h want 80", mar_address); else n_pass++;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00);
    n_checks++; if (ir_out !== 8'h44) $display("FAIL jump_ir: got %h want 44", ir_out); else n_pass++;
    cyc(0, 1, 0, 8'h00);
    n_checks++; if (pc_out !== 8'h81) $display("FAIL jump_then_inc: got %h want 81", pc_out); else n_pass++;
    $display("jump: pc=%h", pc_out);
  endtask

  // RESET_PC = FF: fetch memory[FF], accept, PC wraps to 00 and memory[00] follows.
  task automatic test_wrap();
    int lat;
    mem[8'hFF] = 8'h02; mem[0] = 8'h5A;
    start2 = 1; ir_ready2 = 1; rst_n2 = 1;
    cyc(0, 0, 0, 8'h00);
    start2 = 0;
    lat = 0;
    while (!ir_valid2 && lat < 10) begin cyc(0, 0, 0, 8'h00); lat++; end
    n_checks++; if (lat != 3) $display("FAIL wrap_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (ir_out2 !== 8'h02 || pc_out2 !== 8'hFF)
      $display("FAIL wrap_first: got ir=%h pc=%h want 02 ff", ir_out2, pc_out2);
    else n_pass++;
    cyc(0, 0, 0, 8'h00);
    n_checks++; if (pc_out2 !== 8'h00 || mar_address2 !== 8'h00)
      $display("FAIL wrap_pc: got pc=%h mar=%h want 00 00", pc_out2, mar_address2);
    else n_pass++;
    ir_ready2 = 0;
    lat = 0;
    while (!ir_valid2 && lat < 10) begin cyc(0, 0, 0, 8'h00); lat++; end
    n_checks++; if (ir_out2 !== 8'h5A) $display("FAIL wrap_second: got %h want 5a", ir_out2); else n_pass++;
    $display("wrap: pc=%h ir=%h", pc_out2, ir_out2);
  endtask

  // Reset pulsed in WAIT of the second fetch: pending data is discarded.
  task automatic test_reset_wait();
    mem[0] = 8'h11; mem[1] = 8'h22;
    do_reset();
    cyc(1, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);   // now in WAIT with pc = 01
    rst_n = 0;
    #2;
    n_checks++; if (pc_out !== 8'h00 || mar_address !== 8'h00)
      $display("FAIL rstwait_async_pc: got pc=%h mar=%h want 00 00", pc_out, mar_address);
    else n_pass++;
    n_checks++; if (ir_valid !== 1'b0) $display("FAIL rstwait_valid: got %b want 0", ir_valid); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 8'h00);
      n_checks++; if (ir_valid !== 1'b0 || pc_out !== 8'h00)
        $display("FAIL rstwait_idle[%0d]: got valid=%b pc=%h want 0 00", i, ir_valid, pc_out);
      else n_pass++;
    end
    $display("reset_wait: pc=%h valid=%b", pc_out, ir_valid);
  endtask

  task automatic test_fetch_count();
`ifdef FETCH_UNIT_FETCH_COUNT_EN
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    do_reset();
    n_checks++; if (fetch_count !== 16'd0) $display("FAIL count_reset: got %0d want 0", fetch_count); else n_pass++;
    cyc(1, 1, 0, 8'h00);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 8'h00);
    n_checks++; if (fetch_count !== 16'd3) $display("FAIL count_three: got %0d want 3", fetch_count); else n_pass++;
    $display("fetch_count: %0d", fetch_count);
`endif
  endtask

  // Random ready/jump/start traffic compared cycle by cycle with the model.
  task automatic test_random();
    logic st, rdy, jen;
    logic [7:0] ja;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 254));
    do_reset();
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      jen = ($urandom_range(0, 3) == 0);
      ja  = 8'($urandom_range(0, 255));
      cyc(st, rdy, jen, ja);
      n_checks++; if (pc_out !== m_pc || mar_address !== m_pc)
        $display("FAIL rand_pc[%0d]: got pc=%h mar=%h want %h", i, pc_out, mar_address, m_pc);
      else n_pass++;
      n_checks++; if (ir_valid !== m_valid || halted !== m_halted)
        $display("FAIL rand_flags[%0d]: got valid=%b halted=%b want %b %b", i, ir_valid, halted, m_valid, m_halted);
      else n_pass++;
      if (m_valid) begin
        n_checks++; if (ir_out !== m_ir) $display("FAIL rand_ir[%0d]: got %h want %h", i, ir_out, m_ir); else n_pass++;
      end
`ifdef FETCH_UNIT_FETCH_COUNT_EN
      n_checks++; if (fetch_count !== 16'(m_count))
        $display("FAIL rand_count[%0d]: got %0d want %0d", i, fetch_count, m_count);
      else n_pass++;
`endif
    end
    $display("random: pc=%h model_fetches=%0d", pc_out, m_count);
  endtask

  initial begin
    rst_n = 0; start = 0; ir_ready = 0; jump_en = 0; jump_addr = 0;
    rst_n2 = 0; start2 = 0; ir_ready2 = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    model_reset();
    test_reset();
    test_sequence();
    test_halt();
    test_stall();
    test_jump();
    test_wrap();
    test_reset_wait();
    test_fetch_count();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
